// File: rtl/qerv_rf_ram_if_gen_if.sv
// Core-side bit-serial RF streams plus single-port-pair RAM bus for qerv_rf_ram_if_gen.
// slave = the RF/RAM adapter, master = the core and RAM on the other side.
interface qerv_rf_ram_if_gen_if #(
  parameter int CORE_W   = 4,
  parameter int RF_WIDTH = 8,
  parameter int CSR_REGS = 4
);
  localparam int AW  = 5 + ((CSR_REGS > 0) ? 1 : 0);
  localparam int L2D = $clog2((32 + CSR_REGS) * 32 / RF_WIDTH);

  logic                i_rreq;
  logic                i_wreq;
  logic                o_ready;
  logic [AW-1:0]       i_rreg0;
  logic [AW-1:0]       i_rreg1;
  logic [CORE_W-1:0]   o_rdata0;
  logic [CORE_W-1:0]   o_rdata1;
  logic [AW-1:0]       i_wreg0;
  logic [AW-1:0]       i_wreg1;
  logic                i_wen0;
  logic                i_wen1;
  logic [CORE_W-1:0]   i_wdata0;
  logic [CORE_W-1:0]   i_wdata1;
  logic [L2D-1:0]      o_raddr;
  logic                o_ren;
  logic [RF_WIDTH-1:0] i_rdata;
  logic [L2D-1:0]      o_waddr;
  logic [RF_WIDTH-1:0] o_wdata;
  logic                o_wen;

  modport slave (
    input  i_rreq, i_wreq, i_rreg0, i_rreg1, i_wreg0, i_wreg1,
    input  i_wen0, i_wen1, i_wdata0, i_wdata1, i_rdata,
    output o_ready, o_rdata0, o_rdata1, o_raddr, o_ren, o_waddr, o_wdata, o_wen
  );

  modport master (
    output i_rreq, i_wreq, i_rreg0, i_rreg1, i_wreg0, i_wreg1,
    output i_wen0, i_wen1, i_wdata0, i_wdata1, i_rdata,
    input  o_ready, o_rdata0, o_rdata1, o_raddr, o_ren, o_waddr, o_wdata, o_wen
  );
endinterface

// File: rtl/qerv_rf_ram_if_gen.sv
// Serial-core RF adapter: two CORE_W-bit lanes per direction onto one RF_WIDTH-wide 1R1W RAM.
// Optional QERV_RF_X0_GUARD_EN: suppress writes to x0 and force x0 reads to zero.
module qerv_rf_ram_if_gen #(
  parameter int CORE_W   = 4,
  parameter int RF_WIDTH = 8,
  parameter int CSR_REGS = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  qerv_rf_ram_if_gen_if.slave  bus
);
  localparam int AW    = 5 + ((CSR_REGS > 0) ? 1 : 0);
  localparam int L2D   = $clog2((32 + CSR_REGS) * 32 / RF_WIDTH);
  localparam int RATIO = RF_WIDTH / CORE_W;
  localparam int NW    = 32 / RF_WIDTH;
  localparam int NCH   = 32 / CORE_W;
  localparam int CW    = $clog2(NCH + 3);
`ifdef QERV_RF_X0_GUARD_EN
  localparam bit X0_GUARD = 1'b1;
`else
  localparam bit X0_GUARD = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_t;

  state_t              state_r;
  logic [CW-1:0]       cnt_r;
  logic [AW-1:0]       reg0_r;
  logic [AW-1:0]       reg1_r;
  logic                wen0_r;
  logic                wen1_r;
  logic                zero0_r;
  logic                zero1_r;
  logic [RF_WIDTH-1:0] shadow0_r;
  logic [RF_WIDTH-1:0] buf0_r;
  logic [RF_WIDTH-1:0] buf1_r;
  logic [RF_WIDTH-1:0] acc0_r;
  logic [RF_WIDTH-1:0] acc1_r;

  int                  c_s;
  int                  n_s;
  int                  rd_word_s;
  int                  wr_word0_s;
  int                  wr_word1_s;
  logic                rd_issue_s;
  logic                rd_lane1_s;
  logic                rd_cap0_s;
  logic                rd_chunk_s;
  logic                rd_load_s;
  logic                last_s;
  logic                wr_chunk_s;
  logic                wr_lane0_s;
  logic                wr_lane1_s;
  logic [RF_WIDTH-1:0] rdata1_s;
  logic [RF_WIDTH-1:0] acc0_nxt_s;
  logic [RF_WIDTH-1:0] acc1_nxt_s;

  function automatic logic [L2D-1:0] ram_addr(input logic [AW-1:0] r, input int w);
    return L2D'(int'(r) * NW + w);
  endfunction

  // Cycle-slot decode; c counts from the first cycle after the request was taken.
  // Read: lane0 word w issued at c=w*RATIO, lane1 at c=w*RATIO+1, chunk k shown at c=k+3.
  // Write: chunk k sampled at c=k+1, lane0 word written right after its last chunk, lane1 one cycle later.
  always_comb begin
    c_s        = int'(cnt_r);
    n_s        = c_s + 32'sd1;
    rd_issue_s = (n_s < NW * RATIO) && ((n_s % RATIO) < 32'sd2);
    rd_lane1_s = ((n_s % RATIO) == 32'sd1);
    rd_word_s  = n_s / RATIO;
    rd_cap0_s  = (c_s < NW * RATIO) && ((c_s % RATIO) == 32'sd1);
    rd_chunk_s = (c_s >= 32'sd2);
    rd_load_s  = rd_chunk_s && (((c_s - 32'sd2) % RATIO) == 32'sd0);
    last_s     = (c_s == NCH + 1);
    wr_chunk_s = (c_s >= 32'sd1) && (c_s <= NCH);
    wr_lane0_s = wr_chunk_s && ((c_s % RATIO) == 32'sd0);
    wr_word0_s = c_s / RATIO - 32'sd1;
    wr_lane1_s = (c_s > RATIO) && ((c_s % RATIO) == 32'sd1);
    wr_word1_s = (c_s - 32'sd1) / RATIO - 32'sd1;
    rdata1_s   = zero1_r ? {RF_WIDTH{1'b0}} : bus.i_rdata;
    acc0_nxt_s = {bus.i_wdata0, acc0_r[RF_WIDTH-1:CORE_W]};
    acc1_nxt_s = {bus.i_wdata1, acc1_r[RF_WIDTH-1:CORE_W]};
  end

  // Transfer sequencer: request arbitration, RAM port scheduling and lane buffers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r      <= IDLE;
      cnt_r        <= '0;
      reg0_r       <= '0;
      reg1_r       <= '0;
      wen0_r       <= 1'b0;
      wen1_r       <= 1'b0;
      zero0_r      <= 1'b0;
      zero1_r      <= 1'b0;
      shadow0_r    <= '0;
      buf0_r       <= '0;
      buf1_r       <= '0;
      acc0_r       <= '0;
      acc1_r       <= '0;
      bus.o_ready  <= 1'b0;
      bus.o_ren    <= 1'b0;
      bus.o_wen    <= 1'b0;
      bus.o_raddr  <= '0;
      bus.o_waddr  <= '0;
      bus.o_wdata  <= '0;
      bus.o_rdata0 <= '0;
      bus.o_rdata1 <= '0;
    end else begin
      bus.o_ready <= 1'b0;
      bus.o_ren   <= 1'b0;
      bus.o_wen   <= 1'b0;
      case (state_r)
        IDLE: begin
          cnt_r        <= '0;
          bus.o_rdata0 <= '0;
          bus.o_rdata1 <= '0;
          // A simultaneous read request is dropped in favour of the write.
          if (bus.i_wreq) begin
            state_r     <= WR;
            reg0_r      <= bus.i_wreg0;
            reg1_r      <= bus.i_wreg1;
            wen0_r      <= bus.i_wen0;
            wen1_r      <= bus.i_wen1;
            bus.o_ready <= 1'b1;
          end else if (bus.i_rreq) begin
            state_r     <= RD;
            reg0_r      <= bus.i_rreg0;
            reg1_r      <= bus.i_rreg1;
            zero0_r     <= X0_GUARD && (bus.i_rreg0 == '0);
            zero1_r     <= X0_GUARD && (bus.i_rreg1 == '0);
            bus.o_ren   <= 1'b1;
            bus.o_raddr <= ram_addr(bus.i_rreg0, 32'sd0);
          end
        end
        RD: begin
          cnt_r       <= cnt_r + 1'b1;
          bus.o_ready <= (c_s == 32'sd1);
          if (rd_issue_s) begin
            bus.o_ren   <= 1'b1;
            bus.o_raddr <= ram_addr(rd_lane1_s ? reg1_r : reg0_r, rd_word_s);
          end
          if (rd_cap0_s) begin
            shadow0_r <= zero0_r ? {RF_WIDTH{1'b0}} : bus.i_rdata;
          end
          // Lane1's fresh word arrives exactly at the word boundary, so it bypasses the shadow.
          if (rd_load_s) begin
            bus.o_rdata0 <= shadow0_r[CORE_W-1:0];
            buf0_r       <= shadow0_r >> CORE_W;
            bus.o_rdata1 <= rdata1_s[CORE_W-1:0];
            buf1_r       <= rdata1_s >> CORE_W;
          end else if (rd_chunk_s) begin
            bus.o_rdata0 <= buf0_r[CORE_W-1:0];
            buf0_r       <= buf0_r >> CORE_W;
            bus.o_rdata1 <= buf1_r[CORE_W-1:0];
            buf1_r       <= buf1_r >> CORE_W;
          end
          if (last_s) begin
            state_r <= IDLE;
          end
        end
        WR: begin
          cnt_r <= cnt_r + 1'b1;
          if (wr_chunk_s) begin
            acc0_r <= acc0_nxt_s;
            acc1_r <= acc1_nxt_s;
          end
          // acc1 still holds the whole lane1 word on the cycle after completion.
          if (wr_lane0_s) begin
            bus.o_wen   <= wen0_r && !(X0_GUARD && (reg0_r == '0));
            bus.o_waddr <= ram_addr(reg0_r, wr_word0_s);
            bus.o_wdata <= acc0_nxt_s;
          end else if (wr_lane1_s) begin
            bus.o_wen   <= wen1_r && !(X0_GUARD && (reg1_r == '0));
            bus.o_waddr <= ram_addr(reg1_r, wr_word1_s);
            bus.o_wdata <= acc1_r;
          end
          if (last_s) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_qerv_rf_ram_if_gen.sv
// Directed table-driven bench for qerv_rf_ram_if_gen (CORE_W=4, RF_WIDTH=8, CSR_REGS=4) with a RAM model.
module tb_qerv_rf_ram_if_gen;
  localparam int CORE_W   = 4;
  localparam int RF_WIDTH = 8;
  localparam int CSR_REGS = 4;
`ifdef QERV_RF_X0_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  typedef struct {
    logic [5:0]  r0;
    logic [5:0]  r1;
    bit          e0;
    bit          e1;
    logic [31:0] d0;
    logic [31:0] d1;
    bit          rr;
  } wvec_t;

  typedef struct {
    logic [5:0]  r0;
    logic [5:0]  r1;
    logic [31:0] q0;
    logic [31:0] q1;
  } rvec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  qerv_rf_ram_if_gen_if #(.CORE_W(CORE_W), .RF_WIDTH(RF_WIDTH), .CSR_REGS(CSR_REGS)) bus ();

  qerv_rf_ram_if_gen #(.CORE_W(CORE_W), .RF_WIDTH(RF_WIDTH), .CSR_REGS(CSR_REGS)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  logic [7:0] mem [0:255] = '{default: 8'h00};
  logic [7:0] rdata_q = 8'h00;
  logic [7:0] wlog_a [0:255];
  logic [7:0] wlog_d [0:255];
  int wcnt = 0;
  int rencnt = 0;
  int readycnt = 0;
  int pass_cnt = 0;
  int total_cnt = 0;

  assign bus.i_rdata = rdata_q;

  always @(posedge clk) begin
    if (bus.o_wen) begin
      mem[bus.o_waddr] <= bus.o_wdata;
      wlog_a[wcnt]     <= bus.o_waddr;
      wlog_d[wcnt]     <= bus.o_wdata;
      wcnt             <= wcnt + 1;
    end
    if (bus.o_ren) begin
      rdata_q <= mem[bus.o_raddr];
      rencnt  <= rencnt + 1;
    end
    if (bus.o_ready) readycnt <= readycnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic do_write(input wvec_t v);
    int bw, br, by, n;
    logic [15:0] exp_e [0:7];
    bw = wcnt; br = rencnt; by = readycnt;
    @(posedge clk); #1;
    bus.i_wreq = 1'b1; bus.i_rreq = v.rr;
    bus.i_wreg0 = v.r0; bus.i_wreg1 = v.r1; bus.i_rreg0 = v.r0; bus.i_rreg1 = v.r1;
    bus.i_wen0 = v.e0; bus.i_wen1 = v.e1;
    @(posedge clk); #1;
    bus.i_wreq = 1'b0; bus.i_rreq = 1'b0;
    @(negedge clk); check("wr_ready", 32'(bus.o_ready), 32'd1);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      bus.i_wdata0 = v.d0[4*k +: 4];
      bus.i_wdata1 = v.d1[4*k +: 4];
      bus.i_rreq = v.rr && (k == 2);
      bus.i_wreq = (k == 3);
    end
    @(posedge clk); #1;
    bus.i_wdata0 = 4'h0; bus.i_wdata1 = 4'h0; bus.i_wreq = 1'b0; bus.i_rreq = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n = 0;
    for (int w = 0; w < 4; w++) begin
      if (v.e0 && !(GUARD && v.r0 == 6'd0)) begin exp_e[n] = {v.r0, 2'(w), v.d0[8*w +: 8]}; n++; end
      if (v.e1 && !(GUARD && v.r1 == 6'd0)) begin exp_e[n] = {v.r1, 2'(w), v.d1[8*w +: 8]}; n++; end
    end
    check("wr_count", 32'(wcnt - bw), 32'(n));
    for (int i = 0; i < n; i++) check("wr_addr_data", {16'h0, wlog_a[bw+i], wlog_d[bw+i]}, {16'h0, exp_e[i]});
    check("wr_no_ren", 32'(rencnt - br), 32'd0);
    check("wr_one_ready", 32'(readycnt - by), 32'd1);
  endtask

  task automatic do_read(input logic [5:0] r0, input logic [5:0] r1,
                         output logic [31:0] q0, output logic [31:0] q1);
    int by;
    by = readycnt;
    @(posedge clk); #1;
    bus.i_rreq = 1'b1; bus.i_rreg0 = r0; bus.i_rreg1 = r1;
    @(posedge clk); #1;
    bus.i_rreq = 1'b0;
    @(negedge clk); check("rd_issue0", {23'h0, bus.o_ren, bus.o_raddr}, {23'h0, 1'b1, r0, 2'b00});
    @(posedge clk); #1;
    @(negedge clk); check("rd_issue1", {23'h0, bus.o_ren, bus.o_raddr}, {23'h0, 1'b1, r1, 2'b00});
    @(posedge clk); #1;
    @(negedge clk); check("rd_ready", 32'(bus.o_ready), 32'd1);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      q0[4*k +: 4] = bus.o_rdata0;
      q1[4*k +: 4] = bus.o_rdata1;
    end
    check("rd_one_ready", 32'(readycnt - by), 32'd1);
  endtask

  initial begin
    wvec_t wv [0:5];
    rvec_t rv [0:7];
    wvec_t x0v;
    logic [31:0] q0, q1;

    wv[0] = '{6'd5,  6'd6,  1'b1, 1'b1, 32'hDEADBEEF, 32'h12345678, 1'b0};
    wv[1] = '{6'd1,  6'd31, 1'b1, 1'b1, 32'h00000001, 32'h80000000, 1'b0};
    wv[2] = '{6'd32, 6'd35, 1'b1, 1'b1, 32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0};
    wv[3] = '{6'd33, 6'd34, 1'b1, 1'b1, 32'hFFFFFFFF, 32'h00000000, 1'b0};
    wv[4] = '{6'd7,  6'd8,  1'b1, 1'b0, 32'hCAFEF00D, 32'h13579BDF, 1'b0};
    wv[5] = '{6'd10, 6'd11, 1'b1, 1'b1, 32'h0BADF00D, 32'h76543210, 1'b1};
    rv[0] = '{6'd5,  6'd6,  32'hDEADBEEF, 32'h12345678};
    rv[1] = '{6'd6,  6'd5,  32'h12345678, 32'hDEADBEEF};
    rv[2] = '{6'd1,  6'd31, 32'h00000001, 32'h80000000};
    rv[3] = '{6'd32, 6'd35, 32'hA5A5A5A5, 32'h5A5A5A5A};
    rv[4] = '{6'd33, 6'd34, 32'hFFFFFFFF, 32'h00000000};
    rv[5] = '{6'd7,  6'd8,  32'hCAFEF00D, 32'h00000000};
    rv[6] = '{6'd10, 6'd11, 32'h0BADF00D, 32'h76543210};
    rv[7] = '{6'd35, 6'd32, 32'h5A5A5A5A, 32'hA5A5A5A5};
    x0v   = '{6'd0,  6'd9,  1'b1, 1'b1, 32'hFFFFFFFF, 32'h0F0F0F0F, 1'b0};

    bus.i_rreq = 1'b0; bus.i_wreq = 1'b0;
    bus.i_rreg0 = 6'd0; bus.i_rreg1 = 6'd0; bus.i_wreg0 = 6'd0; bus.i_wreg1 = 6'd0;
    bus.i_wen0 = 1'b0; bus.i_wen1 = 1'b0; bus.i_wdata0 = 4'h0; bus.i_wdata1 = 4'h0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", {21'h0, bus.o_ready, bus.o_ren, bus.o_wen, bus.o_rdata0, bus.o_rdata1}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) do_write(wv[i]);
    for (int i = 0; i < 8; i++) begin
      do_read(rv[i].r0, rv[i].r1, q0, q1);
      check("rd_lane0", q0, rv[i].q0);
      check("rd_lane1", q1, rv[i].q1);
    end

    // Reset while chunk 3 is on the lanes and a prefetch read is being issued.
    @(posedge clk); #1;
    bus.i_rreq = 1'b1; bus.i_rreg0 = 6'd5; bus.i_rreg1 = 6'd6;
    @(posedge clk); #1;
    bus.i_rreq = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    check("pre_rst_ren", 32'(bus.o_ren), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_outs", {21'h0, bus.o_ready, bus.o_ren, bus.o_wen, bus.o_rdata0, bus.o_rdata1}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_read(6'd5, 6'd6, q0, q1);
    check("post_rst_lane0", q0, 32'hDEADBEEF);
    check("post_rst_lane1", q1, 32'h12345678);

    do_write(x0v);
    do_read(6'd0, 6'd9, q0, q1);
    check("x0_lane0", q0, GUARD ? 32'h00000000 : 32'hFFFFFFFF);
    check("x0_lane1", q1, 32'h0F0F0F0F);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
